// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit direction counters plus a direct-mapped BTB.
// Define BRANCH_PRED_GSHARE_EN to index the counters with PC XOR global history (gshare).
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = 6,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [DATA_WIDTH-1:0] upd_pred_target,
  output logic [31:0]           mispredict_cnt
);

  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic [BHT_ENTRIES-1:0][1:0] r_ctr;
  logic [BHT_ENTRIES-1:0]      r_valid;
  logic [BHT_ENTRIES-1:0]      r_isJump;
  logic [TAG_W-1:0]            r_tag    [BHT_ENTRIES];
  logic [DATA_WIDTH-1:0]       r_target [BHT_ENTRIES];
  logic [31:0]                 r_misCnt;

  logic [IDX_W-1:0] w_fetchIdx;
  logic [IDX_W-1:0] w_updIdx;
  logic [IDX_W-1:0] w_fetchBhtIdx;
  logic [IDX_W-1:0] w_updBhtIdx;
  logic [TAG_W-1:0] w_fetchTag;
  logic [TAG_W-1:0] w_updTag;
  logic [1:0]       w_fetchCtr;
  logic [1:0]       w_updCtr;
  logic             w_hit;
  logic             w_predTaken;
  logic             w_mispredict;
  logic             w_condUpd;

  assign w_fetchIdx = fetch_pc[IDX_W+1:2];
  assign w_updIdx   = upd_pc[IDX_W+1:2];
  assign w_fetchTag = fetch_pc[DATA_WIDTH-1:IDX_W+2];
  assign w_updTag   = upd_pc[DATA_WIDTH-1:IDX_W+2];
  assign w_condUpd  = upd_valid && !upd_is_jump;

`ifdef BRANCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // History shifts only on conditional branches; both lookup and update use the pre-shift value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_condUpd) begin
      r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
    end
  end

  assign w_fetchBhtIdx = w_fetchIdx ^ r_ghr;
  assign w_updBhtIdx   = w_updIdx ^ r_ghr;
`else
  assign w_fetchBhtIdx = w_fetchIdx;
  assign w_updBhtIdx   = w_updIdx;
`endif

  assign w_fetchCtr = r_ctr[w_fetchBhtIdx];
  assign w_updCtr   = r_ctr[w_updBhtIdx];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign w_hit       = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);
  assign w_predTaken = rst_n && w_hit && (r_isJump[w_fetchIdx] || w_fetchCtr[1]);

  assign pred_taken  = w_predTaken;
  assign pred_target = w_predTaken ? r_target[w_fetchIdx] : fetch_pc + DATA_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr <= {BHT_ENTRIES{2'b01}};
    end else if (w_condUpd) begin
      if (upd_taken && (w_updCtr != 2'b11)) begin
        r_ctr[w_updBhtIdx] <= w_updCtr + 2'd1;
      end else if (!upd_taken && (w_updCtr != 2'b00)) begin
        r_ctr[w_updBhtIdx] <= w_updCtr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_isJump <= '0;
    end else if (upd_valid && upd_taken) begin
      r_valid[w_updIdx]  <= 1'b1;
      r_isJump[w_updIdx] <= upd_is_jump;
    end
  end

  // Tag and target need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid && upd_taken) begin
      r_tag[w_updIdx]    <= w_updTag;
      r_target[w_updIdx] <= upd_target;
    end
  end

  assign w_mispredict = (upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misCnt <= '0;
    end else if (upd_valid && w_mispredict && (r_misCnt != 32'hFFFF_FFFF)) begin
      r_misCnt <= r_misCnt + 32'd1;
    end
  end

  assign mispredict_cnt = r_misCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: randomized and directed traffic against a spec-level model.
`timescale 1ns/1ps
module tb_branch_predictor;

  localparam int N     = 64;
  localparam int IDX_W = 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic [31:0] mispredict_cnt;

  branch_predictor #(.BHT_ENTRIES(N), .IDX_W(IDX_W), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];
  logic chkReq;
  int   checks;
  int   errors;

  // Reference model: spec-level tables, indexed with plain arithmetic.
  int          mCtr    [N];
  bit          mValid  [N];
  bit          mJump   [N];
  logic [31:0] mTag    [N];
  logic [31:0] mTarget [N];
  logic [31:0] mCnt;
  int          mGhr;

  function automatic int btbIdx(logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int bhtIdx(logic [31:0] pc);
`ifdef BRANCH_PRED_GSHARE_EN
    return int'(((pc >> 2) % N)) ^ mGhr;
`else
    return int'((pc >> 2) % N);
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mCtr[i]   = 1;
      mValid[i] = 0;
      mJump[i]  = 0;
    end
    mCnt = 0;
    mGhr = 0;
  endtask

  task automatic predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    int b;
    b = btbIdx(pc);
    t = 0;
    if (rst_n && mValid[b] && mTag[b] == (pc >> (IDX_W + 2)))
      t = mJump[b] || (mCtr[bhtIdx(pc)] >= 2);
    tgt = t ? mTarget[b] : pc + 32'd4;
  endtask

  task automatic commit();
    int h;
    if ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target))
      if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
    if (!upd_is_jump) begin
      h = bhtIdx(upd_pc);
      if (upd_taken) mCtr[h] = (mCtr[h] == 3) ? 3 : mCtr[h] + 1;
      else           mCtr[h] = (mCtr[h] == 0) ? 0 : mCtr[h] - 1;
      mGhr = ((mGhr << 1) | int'(upd_taken)) % N;
    end
    if (upd_taken) begin
      h = btbIdx(upd_pc);
      mValid[h]  = 1;
      mJump[h]   = upd_is_jump;
      mTag[h]    = upd_pc >> (IDX_W + 2);
      mTarget[h] = upd_target;
    end
  endtask

  task automatic pushExpect();
    exp_t e;
    predict(fetch_pc, e.taken, e.target);
    e.cnt = rst_n ? mCnt : 32'd0;
    expQ.push_back(e);
    chkReq = 1'b1;
  endtask

  // One cycle: drive inputs, queue the expected lookup, then commit the model at the edge.
  task automatic applyStimulus(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                               input logic uj, input logic ut, input logic [31:0] utgt,
                               input logic upt, input logic [31:0] uptg);
    fetch_pc = fpc;  upd_valid = uv;  upd_pc = upc;  upd_is_jump = uj;
    upd_taken = ut;  upd_target = utgt;  upd_pred_taken = upt;  upd_pred_target = uptg;
    pushExpect();
    @(posedge clk);
    if (rst_n && uv) commit();
    #1;
  endtask

  task automatic lookup(input logic [31:0] fpc);
    applyStimulus(fpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per sampled cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (chkReq) begin
      chkReq = 1'b0;
      if (expQ.size() == 0) begin
        checkOutput("queue_underflow", 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, e.taken});
        checkOutput("pred_target", pred_target, e.target);
        checkOutput("mispredict_cnt", mispredict_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rpc, rtgt, ppTgt;
    logic        rj, rt, ppT;
    checks = 0;  errors = 0;  chkReq = 1'b0;
    rst_n = 1'b0;  fetch_pc = 32'h100;  upd_valid = 0;  upd_pc = 0;  upd_is_jump = 0;
    upd_taken = 0;  upd_target = 0;  upd_pred_taken = 0;  upd_pred_target = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    lookup(32'h100);
    applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    lookup(32'h100);
    checkOutput("first_update_target", pred_target, 32'h80);
    repeat (4) applyStimulus(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 32'h80);
    lookup(32'h100);
    applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    lookup(32'h100);
    applyStimulus(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    lookup(32'h100);

    applyStimulus(32'h200, 1, 32'h200, 1, 1, 32'h400, 0, 32'h204);
    lookup(32'h200);
    lookup(32'h1200);

    applyStimulus(32'h300, 1, 32'h300, 1, 1, 32'h500, 0, 32'h304);
    lookup(32'h300);

    // Reset asserted mid-sequence with an update pending; the update must be dropped.
    fetch_pc = 32'h300;  upd_valid = 1;  upd_pc = 32'h100;  upd_is_jump = 0;
    upd_taken = 1;  upd_target = 32'h900;  upd_pred_taken = 0;
    rst_n = 1'b0;
    modelReset();
    #1 pushExpect();
    @(posedge clk);
    #1 rst_n = 1'b1;
    lookup(32'h300);
    lookup(32'h100);

    applyStimulus(32'h40, 1, 32'h40, 0, 1, 32'h10, 0, 32'h44);
    applyStimulus(32'h40, 1, 32'h40, 0, 1, 32'h10, 0, 32'h44);
    applyStimulus(32'h40, 1, 32'h40, 0, 0, 32'h10, 1, 32'h10);
`ifdef BRANCH_PRED_GSHARE_EN
    checkOutput("ghr", {26'd0, dut.r_ghr}, 32'b000110);
    checkOutput("ghr_model", {26'd0, dut.r_ghr}, mGhr);
`endif

    for (int i = 0; i < 600; i++) begin
      rpc  = {26'($urandom_range(0, 3)), 6'd0} << 2 | {24'd0, 6'($urandom_range(0, 7)), 2'b00};
      rpc  = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 7) << 2);
      rtgt = $urandom & 32'hFFFF_FFFC;
      rj   = ($urandom_range(0, 3) == 0);
      rt   = rj ? 1'b1 : 1'($urandom_range(0, 1));
      predict(rpc, ppT, ppTgt);
      if ($urandom_range(0, 1) == 0) begin
        ppT   = 1'($urandom_range(0, 1));
        ppTgt = $urandom_range(0, 1) ? rtgt : ppTgt;
      end
      applyStimulus(($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 7) << 2),
                    1'($urandom_range(0, 3) != 0), rpc, rj, rt, rtgt, ppT, ppTgt);
    end

    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64, number of direction counters and BTB entries; power of two.
REQ-002 SHALL have parameter IDX_W, default 6, equal to log2(BHT_ENTRIES).
REQ-003 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fetch_pc, input, DATA_WIDTH, PC of the instruction being fetched.
REQ-006 SHALL have port pred_taken, output, 1, predicted taken/jump for fetch_pc.
REQ-007 SHALL have port pred_target, output, DATA_WIDTH, predicted next PC.
REQ-008 SHALL have port upd_valid, input, 1, resolved branch or jump presented this cycle.
REQ-009 SHALL have port upd_pc, input, DATA_WIDTH, PC of the resolved instruction.
REQ-010 SHALL have port upd_is_jump, input, 1, resolved instruction is JAL/JALR.
REQ-011 SHALL have port upd_taken, input, 1, resolved take_branch value.
REQ-012 SHALL have port upd_target, input, DATA_WIDTH, resolved target address.
REQ-013 SHALL have port upd_pred_taken, input, 1, prediction made for this instruction at fetch.
REQ-014 SHALL have port upd_pred_target, input, DATA_WIDTH, target predicted for this instruction at fetch.
REQ-015 SHALL have port mispredict_cnt, output, 32, count of mispredictions.

Function
REQ-016 SHALL hold BHT_ENTRIES 2-bit saturating counters and BHT_ENTRIES BTB entries {valid, is_jump, tag = pc[31:IDX_W+2], target}.
REQ-017 SHALL index the BTB with pc[IDX_W+1:2] and the BHT with bht_idx (REQ-033/034).
REQ-018 SHALL form a BTB hit when entry.valid is 1 and entry.tag equals fetch_pc[31:IDX_W+2].
REQ-019 SHALL compute prediction combinationally, zero-cycle latency: pred_taken = hit & (entry.is_jump | counter[1]).
REQ-020 SHALL drive pred_target = entry.target when pred_taken is 1, else fetch_pc + 4 (modulo 2^32).
REQ-021 SHALL, on a clock edge with upd_valid=1 and upd_is_jump=0, increment the counter if upd_taken=1 (saturating at 3) and decrement it if upd_taken=0 (saturating at 0).
REQ-022 SHALL leave counters unchanged for jump updates.
REQ-023 SHALL, when upd_valid=1 and upd_taken=1, write the BTB entry as {1, upd_is_jump, upd_pc tag, upd_target}, replacing any alias.
REQ-024 SHALL leave the BTB unchanged on not-taken updates.
REQ-025 SHALL, when lookup and update hit the same index in the same cycle, return pre-update values to the lookup (no bypass).
REQ-026 SHALL increment mispredict_cnt by 1 when upd_valid=1 and either (upd_pred_taken != upd_taken) or (upd_taken=1 and upd_pred_target != upd_target).
REQ-027 SHALL saturate mispredict_cnt at 32'hFFFF_FFFF.
REQ-028 SHALL ignore all update inputs when upd_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, clear all BTB valid bits, set all counters to 2'b01 (weakly not-taken), and clear mispredict_cnt (and the GHR when configured), asynchronously.
REQ-030 SHALL, during reset, output pred_taken=0 and pred_target=fetch_pc+4.
REQ-031 SHALL discard an update coincident with reset assertion.
REQ-032 SHALL not require BTB tag/target reset.

Configuration
REQ-033 SHALL, with BRANCH_PRED_GSHARE_EN defined, keep an IDX_W-bit global history register, reset 0, shifted left with upd_taken inserted at bit 0 on each conditional (non-jump) update; bht_idx = pc[IDX_W+1:2] XOR GHR, where the update uses the GHR value before that edge's shift.
REQ-034 SHALL, with BRANCH_PRED_GSHARE_EN undefined, contain no GHR and use bht_idx = pc[IDX_W+1:2] (bimodal).

Verification
REQ-035 SHALL check: after reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104, mispredict_cnt=0.
REQ-036 SHALL check: update {pc=0x100, branch, taken, target=0x80, pred_taken=0} -> next cycle fetch_pc=0x100 gives pred_taken=1, pred_target=0x80, mispredict_cnt=1 (bimodal).
REQ-037 SHALL check: 4 not-taken updates on pc=0x100 after REQ-036 -> counter 0, pred_taken=0; 1 taken update -> still 0; 2nd taken -> 1.
REQ-038 SHALL check: jump update {pc=0x200, taken, target=0x400} -> fetch 0x200 predicts 0x400; fetch 0x1200 (same index, different tag) -> pred_taken=0, pred_target=0x1204.
REQ-039 SHALL check: lookup and update of 0x300 in the same cycle -> lookup shows old values; rst_n low mid-sequence -> immediate pred_taken=0, mispredict_cnt=0.
REQ-040 SHALL check: with BRANCH_PRED_GSHARE_EN, taken, taken, not-taken updates -> GHR=6'b000110.
